// File: rtl/outline_drawer.sv
// rtl/outline_drawer.sv - walks a triangle/square outline, one Bresenham pixel per handshake
module outline_drawer #(
   parameter int width  = 4,
   parameter int height = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [4*(width+height)-1:0]    points,
   input  logic                           shape,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [width-1:0]               pix_x,
   output logic [height-1:0]              pix_y,
   output logic                           pix_valid,
   input  logic                           pix_ready,
   output logic                           busy,
   output logic                           done
);

   localparam int vw = width + height;
   localparam int aw = width + 3;
   localparam logic [width-1:0]     one_x = 1;
   localparam logic [height-1:0]    one_y = 1;
   localparam logic signed [aw-1:0] zero  = '0;

   typedef enum logic [1:0] {st_idle, st_load, st_emit, st_done} state_t;

   state_t                 state, state_next;
   logic [4*vw-1:0]        pts;
   logic                   sq;
   logic [1:0]             edge_idx, last_idx, nxt_idx;
   logic [width-1:0]       cur_x, end_x, nx;
   logic [height-1:0]      cur_y, end_y, ny;
   logic signed [aw-1:0]   dx, dy, err, e2, nerr;
   logic                   sx_neg, sy_neg, degen;
   logic                   step_x, step_y, fin;

   logic [vw-1:0]          verts [4];
   logic [vw-1:0]          start_v, end_v;
   logic signed [aw-1:0]   ddx, ddy;

   function automatic logic signed [aw-1:0] ext_x(input logic [width-1:0] v);
      return signed'({{(aw-width){1'b0}}, v});
   endfunction

   function automatic logic signed [aw-1:0] ext_y(input logic [height-1:0] v);
      return signed'({{(aw-height){1'b0}}, v});
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) verts[i] = pts[i*vw +: vw];
      last_idx = sq ? 2'd3 : 2'd2;
      nxt_idx  = (edge_idx == last_idx) ? 2'd0 : edge_idx + 2'd1;
      start_v  = verts[edge_idx];
      end_v    = verts[nxt_idx];
      ddx      = ext_x(end_v[width-1:0]) - ext_x(start_v[width-1:0]);
      ddy      = ext_y(end_v[vw-1:width]) - ext_y(start_v[vw-1:width]);
   end

   // Bresenham step from the current pixel; fin marks the edge's end (or a zero-length edge)
   always_comb begin
      e2     = err <<< 1;
      step_x = (e2 >= dy);
      step_y = (e2 <= dx);
      nerr   = err + (step_x ? dy : zero) + (step_y ? dx : zero);
      nx     = cur_x;
      ny     = cur_y;
      if (step_x) nx = sx_neg ? cur_x - one_x : cur_x + one_x;
      if (step_y) ny = sy_neg ? cur_y - one_y : cur_y + one_y;
      fin    = degen || (nx == end_x && ny == end_y);
   end

   always_comb begin
      state_next = state;
      case (state)
         st_idle: if (in_valid) state_next = st_load;
         st_load: state_next = st_emit;
         st_emit: if (pix_ready && fin)
                     state_next = (edge_idx == last_idx) ? st_done : st_load;
         st_done: state_next = st_idle;
         default: state_next = st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= st_idle;
         pts      <= '0;
         sq       <= 1'b0;
         edge_idx <= 2'd0;
         cur_x    <= '0;
         cur_y    <= '0;
         end_x    <= '0;
         end_y    <= '0;
         dx       <= '0;
         dy       <= '0;
         err      <= '0;
         sx_neg   <= 1'b0;
         sy_neg   <= 1'b0;
         degen    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            st_idle: if (in_valid) begin
               pts      <= points;
               sq       <= shape;
               edge_idx <= 2'd0;
            end
            st_load: begin
               cur_x  <= start_v[width-1:0];
               cur_y  <= start_v[vw-1:width];
               end_x  <= end_v[width-1:0];
               end_y  <= end_v[vw-1:width];
               dx     <= (ddx < 0) ? -ddx : ddx;
               dy     <= (ddy < 0) ? ddy : -ddy;
               err    <= ((ddx < 0) ? -ddx : ddx) + ((ddy < 0) ? ddy : -ddy);
               sx_neg <= !(ddx > 0);
               sy_neg <= !(ddy > 0);
               degen  <= (start_v == end_v);
            end
            st_emit: if (pix_ready) begin
               if (fin) begin
                  if (edge_idx != last_idx) edge_idx <= edge_idx + 2'd1;
               end else begin
                  cur_x <= nx;
                  cur_y <= ny;
                  err   <= nerr;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = rst_n && (state == st_idle);
   assign busy      = (state != st_idle);
   assign pix_valid = (state == st_emit);
   assign done      = (state == st_done);
   assign pix_x     = cur_x;
   assign pix_y     = cur_y;

endmodule

// File: tb/tb_outline_drawer.sv
// tb/tb_outline_drawer.sv - directed and random outline drawing against a reference model
module tb_outline_drawer;

   typedef int pq_t[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic [27:0] points;
   logic        shape;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  pix_x;
   logic [2:0]  pix_y;
   logic        pix_valid;
   logic        pix_ready;
   logic        busy;
   logic        done;

   int checks = 0;
   int fails  = 0;

   outline_drawer dut (
      .clk(clk), .rst_n(rst_n), .points(points), .shape(shape),
      .in_valid(in_valid), .in_ready(in_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [27:0] pk(input int x0, y0, x1, y1, x2, y2, x3, y3);
      return {3'(y3), 4'(x3), 3'(y2), 4'(x2), 3'(y1), 4'(x1), 3'(y0), 4'(x0)};
   endfunction

   // Pixels encoded as x*8+y; each edge from start up to but excluding its end vertex
   function automatic pq_t model(input logic [27:0] p, input bit sq);
      pq_t q;
      int n, x0, y0, x1, y1, dx, dy, sx, sy, err, e2, x, y;
      q = {};
      n = sq ? 4 : 3;
      for (int e = 0; e < n; e++) begin
         x0 = int'(p[e*7 +: 4]);
         y0 = int'(p[e*7+4 +: 3]);
         x1 = int'(p[((e+1)%n)*7 +: 4]);
         y1 = int'(p[((e+1)%n)*7+4 +: 3]);
         if (x0 == x1 && y0 == y1) begin
            q.push_back(x0*8 + y0);
         end else begin
            dx = (x1 > x0) ? x1 - x0 : x0 - x1;
            dy = (y1 > y0) ? y0 - y1 : y1 - y0;
            sx = (x1 > x0) ? 1 : -1;
            sy = (y1 > y0) ? 1 : -1;
            err = dx + dy;
            x = x0;
            y = y0;
            for (int k = 0; k < 64; k++) begin
               q.push_back(x*8 + y);
               e2 = 2*err;
               if (e2 >= dy) begin err += dy; x += sx; end
               if (e2 <= dx) begin err += dx; y += sy; end
               if (x == x1 && y == y1) break;
            end
         end
      end
      return q;
   endfunction

   // mode 0: pix_ready high; 1: pattern 1,0,0,1; 2: random. Modes 1/2 also push in_valid while busy.
   task automatic draw(input logic [27:0] p, input bit sq, input pq_t exp, input int mode,
                       output pq_t got);
      int cyc, hs, pat, held;
      bit stalled, fin, r;
      got = {};
      @(negedge clk);
      chk("in_ready_idle", int'(in_ready), 1);
      points = p; shape = sq; in_valid = 1'b1; pix_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1; hs = 0; pat = 0; stalled = 0; fin = 0; held = 0;
      chk("load_bubble", int'({busy, pix_valid, in_ready}), 4);
      while (!fin && cyc < 400) begin
         if (mode != 0) begin
            in_valid = 1'b1; points = 28'($urandom); shape = 1'($urandom);
         end
         if (done) begin
            in_valid = 1'b0;
            chk("pixel_count", hs, exp.size());
            chk("done_no_pix", int'(pix_valid), 0);
            if (mode == 0) chk("shape_cycles", cyc, exp.size() + (sq ? 4 : 3) + 1);
            fin = 1;
         end else begin
            if (stalled) chk("stall_hold", int'({pix_valid, pix_x, pix_y}), held);
            chk("in_ready_busy", int'(in_ready), 0);
            if (pix_valid) begin
               r = (mode == 0) ? 1'b1 :
                   (mode == 1) ? (pat % 4 == 0 || pat % 4 == 3) :
                   ($urandom_range(0, 3) != 0);
               pat++;
               pix_ready = r;
               if (r) begin
                  got.push_back(int'(pix_x)*8 + int'(pix_y));
                  if (hs < exp.size()) chk("pixel", int'(pix_x)*8 + int'(pix_y), exp[hs]);
                  else chk("extra_pixel", hs, exp.size() - 1);
                  hs++;
               end
               stalled = !r;
               held = int'({pix_valid, pix_x, pix_y});
            end else begin
               pix_ready = 1'($urandom);
               stalled = 0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("after_done", int'({done, busy, in_ready}), 1);
   endtask

   logic [27:0] p;
   pq_t exp_q, got_q;
   int  hs, cyc;

   initial begin
      rst_n = 1'b0; points = '0; shape = 1'b0; in_valid = 1'b0; pix_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", int'({in_ready, pix_valid, busy, done, pix_x, pix_y}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", int'(in_ready), 1);

      // Triangle (0,0),(3,0),(0,3)
      p = pk(0, 0, 3, 0, 0, 3, 0, 0);
      exp_q = {0*8+0, 1*8+0, 2*8+0, 3*8+0, 2*8+1, 1*8+2, 0*8+3, 0*8+2, 0*8+1};
      draw(p, 1'b0, exp_q, 0, got_q);

      // Square (2,2),(5,2),(5,5),(2,5)
      exp_q = {2*8+2, 3*8+2, 4*8+2, 5*8+2, 5*8+3, 5*8+4, 5*8+5, 4*8+5, 3*8+5, 2*8+5,
               2*8+4, 2*8+3};
      draw(pk(2, 2, 5, 2, 5, 5, 2, 5), 1'b1, exp_q, 0, got_q);

      // Steep edge: y climbs by one per pixel on edge 0
      p = pk(0, 0, 2, 7, 0, 7, 0, 0);
      draw(p, 1'b0, model(p, 1'b0), 0, got_q);
      chk("steep_count", got_q.size(), 16);
      for (int i = 1; i < 7 && i < got_q.size(); i++) begin
         chk("steep_y_step", got_q[i] % 8, got_q[i-1] % 8 + 1);
         chk("steep_x_mono", int'(got_q[i] / 8 >= got_q[i-1] / 8), 1);
      end

      // Degenerate: all vertices (4,4)
      exp_q = {4*8+4, 4*8+4, 4*8+4};
      draw(pk(4, 4, 4, 4, 4, 4, 1, 6), 1'b0, exp_q, 0, got_q);

      // Backpressure with in_valid pushed while busy
      exp_q = {0*8+0, 1*8+0, 2*8+0, 3*8+0, 2*8+1, 1*8+2, 0*8+3, 0*8+2, 0*8+1};
      draw(pk(0, 0, 3, 0, 0, 3, 0, 0), 1'b0, exp_q, 1, got_q);

      // Reset after the 4th handshake
      @(negedge clk);
      points = pk(0, 0, 3, 0, 0, 3, 0, 0); shape = 1'b0; in_valid = 1'b1; pix_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; hs = 0; cyc = 0;
      while (hs < 4 && cyc < 50) begin
         if (pix_valid) begin
            chk("pre_reset_pixel", int'(pix_x)*8 + int'(pix_y), exp_q[hs]);
            hs++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("pre_reset_handshakes", hs, 4);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_reset", int'({pix_valid, busy, done, in_ready}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset", int'({in_ready, done, busy}), 4);
      draw(pk(0, 0, 3, 0, 0, 3, 0, 0), 1'b0, exp_q, 0, got_q);

      // Random shapes against the model
      for (int i = 0; i < 9; i++) begin
         p = 28'($urandom);
         shape = 1'($urandom);
         draw(p, shape, model(p, shape), i % 3, got_q);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
